// File: rtl/pixel_window_server.sv
// Pixel store for stereo block matching: streams in a 16x16 reference window F and
// a 16x79 search strip G, then serves registered pixel reads to the matcher.
module pixel_window_server #(
    parameter int FW = 16,
    parameter int FH = 16,
    parameter int GW = 79,
    parameter int PW = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic [PW-1:0]   load_data,
    output logic            load_ready,
    input  logic            startsig,
    input  logic            finalstart,
    input  logic [6:0]      vector_xf,
    input  logic [6:0]      vector_xg,
    input  logic [3:0]      vector_y,
    output logic [PW-1:0]   getfdata,
    output logic [PW-1:0]   gdata,
    output logic [2*PW-1:0] get2f,
    output logic            frame_ready,
    output logic            serving,
    output logic            addr_err,
    output logic            overrun
);

    localparam int FN = FW * FH;
    localparam int GN = GW * FH;
    localparam int FA = $clog2(FN);
    localparam int GA = $clog2(GN);
    localparam logic [GA-1:0] F_LAST = GA'(FN - 1);
    localparam logic [GA-1:0] G_LAST = GA'(GN - 1);

    typedef enum logic [1:0] {LOAD_F, LOAD_G, READY, SERVE} state_t;

    state_t          state_q, state_d;
    logic [GA-1:0]   cnt_q, cnt_d;
    logic            load_ready_q, load_ready_d;
    logic            overrun_q, overrun_d;
    logic            addr_err_q, addr_err_d;
    logic [PW-1:0]   getf_q, getf_d;
    logic [PW-1:0]   gdat_q, gdat_d;
    logic [2*PW-1:0] get2f_q, get2f_d;
    logic            f_we, g_we;
    logic            f_ok, g_ok;
    logic [FA-1:0]   f_rd_idx;
    logic [GA-1:0]   g_rd_idx;
    logic [PW-1:0]   f_pix, g_pix;

    logic [PW-1:0] f_mem [FN];
    logic [PW-1:0] g_mem [GN];

    function automatic logic [2*PW-1:0] sq(input logic [PW-1:0] p);
        return (2*PW)'(p) * (2*PW)'(p);
    endfunction

    // Control: load sequencing, pass handshake and sticky error flags
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q;
        f_we       = 1'b0;
        g_we       = 1'b0;
        case (state_q)
            LOAD_F: begin
                if (startsig) overrun_d = 1'b1;
                if (load_valid && load_ready_q) begin
                    f_we = 1'b1;
                    if (cnt_q == F_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD_G;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LOAD_G: begin
                if (startsig) overrun_d = 1'b1;
                if (load_valid && load_ready_q) begin
                    g_we = 1'b1;
                    if (cnt_q == G_LAST) begin
                        cnt_d   = '0;
                        state_d = READY;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            READY: begin
                if (startsig) state_d = SERVE;
            end
            SERVE: begin
                if (finalstart) state_d = LOAD_F;
            end
            default: state_d = LOAD_F;
        endcase
        load_ready_d = (state_d == LOAD_F) || (state_d == LOAD_G);
    end

    // Read path: range-checked addresses; out-of-range columns read as zero
    always_comb begin
        f_ok     = vector_xf < 7'(FW);
        g_ok     = vector_xg < 7'(GW);
        f_rd_idx = f_ok ? FA'(FA'(vector_y) * FA'(FW) + FA'(vector_xf)) : '0;
        g_rd_idx = g_ok ? GA'(GA'(vector_y) * GA'(GW) + GA'(vector_xg)) : '0;
        f_pix    = f_mem[f_rd_idx];
        g_pix    = g_mem[g_rd_idx];
        getf_d     = getf_q;
        gdat_d     = gdat_q;
        get2f_d    = get2f_q;
        addr_err_d = addr_err_q;
        if (state_q == SERVE) begin
            getf_d  = f_ok ? f_pix : '0;
            gdat_d  = g_ok ? g_pix : '0;
            get2f_d = f_ok ? sq(f_pix) : '0;
            if (!f_ok || !g_ok) addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LOAD_F;
            cnt_q        <= '0;
            load_ready_q <= 1'b0;
            overrun_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            getf_q       <= '0;
            gdat_q       <= '0;
            get2f_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_ready_q <= load_ready_d;
            overrun_q    <= overrun_d;
            addr_err_q   <= addr_err_d;
            getf_q       <= getf_d;
            gdat_q       <= gdat_d;
            get2f_q      <= get2f_d;
        end
    end

    // Pixel stores are never cleared; validity is tracked by the state machine
    always_ff @(posedge clk) begin
        if (f_we) f_mem[cnt_q[FA-1:0]] <= load_data;
        if (g_we) g_mem[cnt_q] <= load_data;
    end

    assign load_ready  = load_ready_q;
    assign frame_ready = (state_q == READY) || (state_q == SERVE);
    assign serving     = (state_q == SERVE);
    assign addr_err    = addr_err_q;
    assign overrun     = overrun_q;
    assign getfdata    = getf_q;
    assign gdata       = gdat_q;
    assign get2f       = get2f_q;

endmodule
